mul_sched: RTL and testbench
============================

# mul_sched

Two-client scheduler and sequencer for the 4-bit shift-add multiplier datapath. It arbitrates round-robin between two requesters and loads the winner's operands into the datapath. It then drives the datapath's one-hot Load/Shift/Add controls from its m0 feedback and returns the product tagged with the requester id. It sits between client logic and the multiplier datapath; the datapath shares this block's clk and reset.

## Interface
- WIDTH, 4, operand width; also the number of shift steps per multiply.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- req0, req1  in  1  request from client 0/1; level, held until granted.
- a0, b0, a1, b1  in  WIDTH  multiplicand (a) and multiplier (b) per client; stable while req high.
- gnt0, gnt1  out  1  one-cycle grant; operands are sampled in this cycle.
- m0  in  1  datapath multiplier LSB.
- product  in  2*WIDTH  datapath product.
- word1, word2  out  WIDTH  multiplicand and multiplier to the datapath (the winner's a/b in the grant cycle, else 0).
- load, shift, add  out  1  datapath controls; at most one high per cycle.
- busy  out  1  high when state is not IDLE.
- result  out  2*WIDTH  equals product while result_valid is high, else 0.
- result_valid  out  1  one-cycle pulse in DONE.
- result_id  out  1  client that owns the result.

## Operation
- States: IDLE, EVAL, SHIFT, DONE. Registers: state, cnt (clog2(WIDTH) bits), owner, last_id.
- IDLE:
  - If any req is high, pick the winner: if both are high, the client that is not last_id wins; otherwise the single requester wins.
  - Assert gnt of the winner and assert load with word1/word2 = its a/b.
  - Set owner = last_id = winner, cnt = 0, and go to EVAL.
- EVAL:
  - If m0 = 1, assert add and go to SHIFT.
  - Otherwise assert shift; if cnt == WIDTH-1 go to DONE, else increment cnt and stay in EVAL.
- SHIFT: assert shift; if cnt == WIDTH-1 go to DONE, else increment cnt and go to EVAL.
- DONE: result_valid = 1, result = product, result_id = owner; no datapath control asserted; go to IDLE.
- Grants are issued only in IDLE. A req still high in the cycle after its gnt counts as a new request.
- Arithmetic is carried entirely by the datapath (add carry lands in its carry bit and shifts into product). The controller never modifies the data.
- Reset (asynchronous, any state, including mid-multiply):
  - state = IDLE, cnt = 0, owner = 0, last_id = 1 (client 0 wins the first tie).
  - All outputs go to 0 immediately and no result_valid is emitted for the aborted operation.
  - A request pending at reset release is re-granted normally.

## Timing
- Outputs are a combinational function of state and inputs; no added output register stages.
- Grant cycle is T0, and load is applied at the T0 edge. The first EVAL is T0+1 (m0 is valid there).
- Each multiplier bit costs 1 cycle (bit = 0) or 2 cycles (bit = 1).
- result_valid is high in cycle T0 + 1 + WIDTH + popcount(b).
- The next grant is possible at earliest in the cycle after DONE. Back-to-back throughput is 2 + WIDTH + popcount(b) cycles per operation.
- A client's req is ignored while busy; it waits with no loss.

## Structure
- Shared package mul_sched_pkg: state encoding constants (IDLE, EVAL, SHIFT, DONE), default WIDTH, client-id width constant.
- Sub-module rr_arb2: a combinational two-way round-robin pick from req0/req1 and last_id. The FSM, counter and output decode stay in mul_sched.
- The top-level test harness instantiates mul_sched together with the existing multiplier datapath.

## Test plan
- Single request, req0, a0=3, b0=5 -> gnt0 at T0 with load and word1=3, word2=5; add pulses at T0+1 and T0+4; result_valid at T0+7 with result=8'd15, result_id=0.
- Multiplier zero, req1, a1=9, b1=0 -> four shift-only cycles, no add; result_valid at T0+5 with result=0, result_id=1.
- Carry path, a0=15, b0=15 -> four adds interleaved with four shifts; result_valid at T0+9 with result=8'hE1 (225).
- Contention: req0 and req1 both held high from reset release, b=1 for both -> grant order 0, 1, 0, 1; each grant arrives exactly one cycle after the previous DONE; result_ids alternate.
- Reset mid-operation: reset asserted during SHIFT of a 7x6 multiply -> load/shift/add/busy/result_valid all 0 at once, no result emitted. After release, req0 still high -> re-granted and returns 8'd42.
- Control exclusivity: random operands for 200 operations -> load, shift, add never overlap; result equals a*b for every operation.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the two-client shift-add multiplier scheduler.
`default_nettype none

package mul_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int ID_W      = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_sched_if.sv
// Client request/grant, datapath control and result bundle for mul_sched.
`default_nettype none

interface mul_sched_if
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                   req0;
  logic                   req1;
  logic [WIDTH-1:0]       a0;
  logic [WIDTH-1:0]       b0;
  logic [WIDTH-1:0]       a1;
  logic [WIDTH-1:0]       b1;
  logic                   gnt0;
  logic                   gnt1;
  logic                   m0;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       word1;
  logic [WIDTH-1:0]       word2;
  logic                   load;
  logic                   shift;
  logic                   add;
  logic                   busy;
  logic [2*WIDTH-1:0]     result;
  logic                   result_valid;
  logic                   result_id;

  // master: clients plus datapath feedback; slave: the scheduler itself
  modport master (
    output req0, req1, a0, b0, a1, b1, m0, product,
    input  gnt0, gnt1, word1, word2, load, shift, add, busy,
           result, result_valid, result_id
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, m0, product,
    output gnt0, gnt1, word1, word2, load, shift, add, busy,
           result, result_valid, result_id
  );

endinterface

`default_nettype wire

// File: rtl/mul_sched_rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the client that did not win last time goes.
`default_nettype none

module rr_arb2
  import mul_sched_pkg::*;
(
  input  logic            req0,
  input  logic            req1,
  input  logic [ID_W-1:0] last_id,
  output logic            valid,
  output logic [ID_W-1:0] winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = (req0 && req1) ? ~last_id : ID_W'(req1);
  end

endmodule

`default_nettype wire

// File: rtl/mul_sched.sv
// Round-robin scheduler and Load/Shift/Add sequencer for the shift-add multiplier datapath.
`default_nettype none

module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic        clk,
  input  logic        reset,
  mul_sched_if.slave  bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;

  rr_arb2 u_arb (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .last_id (last_id_q),
    .valid   (pick_valid),
    .winner  (pick_id)
  );

  // last_id resets to 1 so client 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      last_id_q <= ID_W'(1);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      last_id_q <= last_id_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    owner_d          = owner_q;
    last_id_d        = last_id_q;
    bus.gnt0         = 1'b0;
    bus.gnt1         = 1'b0;
    bus.word1        = '0;
    bus.word2        = '0;
    bus.load         = 1'b0;
    bus.shift        = 1'b0;
    bus.add          = 1'b0;
    bus.result       = '0;
    bus.result_valid = 1'b0;
    bus.result_id    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          bus.gnt0  = (pick_id == ID_W'(0));
          bus.gnt1  = (pick_id == ID_W'(1));
          bus.load  = 1'b1;
          bus.word1 = (pick_id == ID_W'(1)) ? bus.a1 : bus.a0;
          bus.word2 = (pick_id == ID_W'(1)) ? bus.b1 : bus.b0;
          owner_d   = pick_id;
          last_id_d = pick_id;
          cnt_d     = '0;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        if (bus.m0) begin
          bus.add = 1'b1;
          state_d = SHIFT;
        end else begin
          bus.shift = 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        bus.shift = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
        else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = EVAL;
        end
      end
      DONE: begin
        bus.result_valid = 1'b1;
        bus.result       = bus.product;
        bus.result_id    = owner_q[0];
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are combinational from inputs, so force them quiet while reset is held
    if (reset) begin
      bus.gnt0         = 1'b0;
      bus.gnt1         = 1'b0;
      bus.word1        = '0;
      bus.word2        = '0;
      bus.load         = 1'b0;
      bus.shift        = 1'b0;
      bus.add          = 1'b0;
      bus.result       = '0;
      bus.result_valid = 1'b0;
      bus.result_id    = 1'b0;
    end
  end

  assign bus.busy = (state_q != IDLE) && !reset;

endmodule

`default_nettype wire

// File: tb/tb_mul_sched.sv
// Bench for mul_sched with a behavioural shift-add datapath and a timing-level scoreboard.
`default_nettype none

module tb_mul_sched;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_sched_if #(.WIDTH(W)) bus ();

  mul_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Shift-add datapath: {C,A,Q}, multiplicand M
  logic [W-1:0] dp_a, dp_q, dp_m;
  logic         dp_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_a <= '0; dp_q <= '0; dp_m <= '0; dp_c <= 1'b0;
    end else if (bus.load) begin
      dp_a <= '0; dp_c <= 1'b0; dp_m <= bus.word1; dp_q <= bus.word2;
    end else if (bus.add) begin
      {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_m};
    end else if (bus.shift) begin
      {dp_c, dp_a, dp_q} <= {1'b0, dp_c, dp_a, dp_q[W-1:1]};
    end
  end

  assign bus.m0      = dp_q[0];
  assign bus.product = {dp_a, dp_q};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errs++;
    $display("FAIL %s timed out at cycle %0d", nm, cyc);
  endtask

  // Scoreboard: one operation in flight, result due 1+W+popcount(b) cycles after its grant
  bit         m_pend = 1'b0;
  int         m_due  = 0;
  logic [7:0] m_res  = '0;
  bit         m_id   = 1'b0;
  bit         m_last = 1'b1;

  always @(negedge clk) begin
    bit any, w, exp_rv;
    logic [W-1:0] ea, eb;
    if (reset) begin
      chk("reset_quiet",
          {bus.gnt0, bus.gnt1, bus.load, bus.shift, bus.add, bus.busy, bus.result_valid, bus.result_id},
          8'h00);
      chk("reset_data", {bus.word1, bus.word2, bus.result}, '0);
      m_pend = 1'b0;
      m_last = 1'b1;
    end else begin
      exp_rv = m_pend && (cyc == m_due);
      chk("result_valid", bus.result_valid, exp_rv);
      chk("result", bus.result, exp_rv ? m_res : 8'h00);
      if (exp_rv) chk("result_id", bus.result_id, m_id);
      chk("busy", bus.busy, m_pend);
      chk("ctrl_onehot0", ($countones({bus.load, bus.shift, bus.add}) <= 1), 1'b1);
      if (!m_pend) begin
        any = bus.req0 | bus.req1;
        w   = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        ea  = w ? bus.a1 : bus.a0;
        eb  = w ? bus.b1 : bus.b0;
        chk("grant", {bus.gnt1, bus.gnt0}, any ? (w ? 2'b10 : 2'b01) : 2'b00);
        chk("load", bus.load, any);
        chk("words", {bus.word1, bus.word2}, any ? {ea, eb} : '0);
        if (any) begin
          m_pend = 1'b1;
          m_due  = cyc + 1 + W + $countones(eb);
          m_res  = ea * eb;
          m_id   = w;
          m_last = w;
        end
      end else begin
        chk("no_grant_busy", {bus.gnt1, bus.gnt0, bus.load}, 3'b000);
      end
      if (exp_rv) m_pend = 1'b0;
    end
  end

  task automatic wait_gnt(input string nm, output int t, output bit who, output bit ok);
    ok = 1'b0; t = 0; who = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        t = cyc; who = bus.gnt1; ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout({nm, "_gnt"});
  endtask

  task automatic wait_res(input string nm, output int t, output int adds, output bit ok);
    ok = 1'b0; t = 0; adds = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.add) adds++;
      if (bus.result_valid) begin
        t = cyc; ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout({nm, "_res"});
  endtask

  task automatic run_single(input string nm, input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [7:0] er, input int lat, input int nadd);
    int t0, tr, adds;
    bit who, ok;
    @(posedge clk); #1;
    if (id) begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
    else    begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
    wait_gnt(nm, t0, who, ok);
    if (ok) begin
      chk({nm, "_gnt_id"}, who, id);
      chk({nm, "_load"}, bus.load, 1'b1);
      chk({nm, "_word1"}, bus.word1, a);
      chk({nm, "_word2"}, bus.word2, b);
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_res(nm, tr, adds, ok);
    if (ok) begin
      chk({nm, "_latency"}, tr - t0, lat);
      chk({nm, "_value"}, bus.result, er);
      chk({nm, "_id"}, bus.result_id, id);
      chk({nm, "_adds"}, adds, nadd);
    end
  endtask

  initial begin
    int t0, tr, adds, prev_done;
    bit who, ok;
    bit exp_order [4];
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_single("mul3x5",   1'b0, 4'd3,  4'd5,  8'd15,  7, 2);
    run_single("mul9x0",   1'b1, 4'd9,  4'd0,  8'd0,   5, 0);
    run_single("mul15x15", 1'b0, 4'd15, 4'd15, 8'hE1,  9, 4);

    // Contention from reset release: strict alternation, each grant right after the previous DONE
    @(posedge clk); #1;
    reset = 1'b1;
    bus.a0 = 4'd2; bus.b0 = 4'd1; bus.a1 = 4'd3; bus.b1 = 4'd1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    prev_done = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt("rr", t0, who, ok);
      if (!ok) break;
      chk("rr_order", who, exp_order[i]);
      if (i > 0) chk("rr_gap", t0, prev_done + 1);
      if (i == 3) begin
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      wait_res("rr", tr, adds, ok);
      if (!ok) break;
      chk("rr_result_id", bus.result_id, exp_order[i]);
      chk("rr_value", bus.result, exp_order[i] ? 8'd3 : 8'd2);
      prev_done = tr;
    end

    // Abort a 7x6 multiply in SHIFT, then re-grant the still-pending request
    @(posedge clk); #1;
    bus.a0 = 4'd7; bus.b0 = 4'd6; bus.req0 = 1'b1;
    wait_gnt("abort", t0, who, ok);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_busy", {bus.busy, bus.shift, bus.add}, 3'b110);
    reset = 1'b1;
    #1;
    chk("abort_quiet", {bus.load, bus.shift, bus.add, bus.busy, bus.result_valid}, 5'b00000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_gnt("regrant", t0, who, ok);
    if (ok) chk("regrant_first_cycle", t0, cyc);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    wait_res("regrant", tr, adds, ok);
    if (ok) begin
      chk("regrant_value", bus.result, 8'd42);
      chk("regrant_latency", tr - t0, 7);
    end

    // Random operands and request patterns; the scoreboard checks every cycle
    for (int n = 0; n < 200; n++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(1, 3);
      bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      bus.a1 = W'($urandom); bus.b1 = W'($urandom);
      bus.req0 = r[0]; bus.req1 = r[1];
      wait_gnt("rand", t0, who, ok);
      if (!ok) break;
      @(posedge clk); #1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      wait_res("rand", tr, adds, ok);
      if (!ok) break;
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
